// File: rtl/adma_desc_queue.sv
// adma_desc_queue: per-channel descriptor ring for the AXI DMA.
// Accepts descriptors from the CSR block, issues them one at a time to the
// transfer engine and reports completion status and sticky IRQ sources.
// Optional feature macro: ADMA_DESC_CYCLIC_EN (cyclic re-issue of stored
// descriptors while chn_xfer_cyclic_i is high).
module adma_desc_queue #(
    parameter int SRC_ADDR_W     = 32,
    parameter int DST_ADDR_W     = 32,
    parameter int DMA_LENGTH_W   = 16,
    parameter int DMA_DESC_DEPTH = 4,
    parameter int DMA_XFER_ID_W  = $clog2(DMA_DESC_DEPTH)
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      chn_ctrl_en_i,
    input  logic                      chn_xfer_cyclic_i,
    input  logic                      desc_wr_vld_i,
    output logic                      desc_wr_rdy_o,
    input  logic [SRC_ADDR_W-1:0]     desc_src_addr_i,
    input  logic [DST_ADDR_W-1:0]     desc_dst_addr_i,
    input  logic [DMA_LENGTH_W-1:0]   desc_xfer_xlen_i,
    input  logic [DMA_LENGTH_W-1:0]   desc_xfer_ylen_i,
    input  logic [DMA_LENGTH_W-1:0]   desc_src_strd_i,
    input  logic [DMA_LENGTH_W-1:0]   desc_dst_strd_i,
    output logic                      desc_rd_vld_o,
    input  logic                      desc_rd_rdy_i,
    output logic [DMA_XFER_ID_W-1:0]  desc_rd_id_o,
    output logic [SRC_ADDR_W-1:0]     desc_rd_src_addr_o,
    output logic [DST_ADDR_W-1:0]     desc_rd_dst_addr_o,
    output logic [DMA_LENGTH_W-1:0]   desc_rd_xfer_xlen_o,
    output logic [DMA_LENGTH_W-1:0]   desc_rd_xfer_ylen_o,
    output logic [DMA_LENGTH_W-1:0]   desc_rd_src_strd_o,
    output logic [DMA_LENGTH_W-1:0]   desc_rd_dst_strd_o,
    input  logic                      xfer_cmpl_i,
    output logic [DMA_XFER_ID_W-1:0]  xfer_id_o,
    output logic [DMA_DESC_DEPTH-1:0] xfer_done_o,
    output logic [DMA_XFER_ID_W-1:0]  active_xfer_id_o,
    output logic [DMA_LENGTH_W-1:0]   active_xfer_len_o,
    output logic                      irq_com_o,
    output logic                      irq_qed_o,
    input  logic [1:0]                irq_clr_i
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam int PTR_W = DMA_XFER_ID_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] iss_ptr_reg, iss_ptr_next;
    logic [PTR_W-1:0] head_ptr_reg, head_ptr_next;
    logic [PTR_W-1:0] count;
    logic [PTR_W-1:0] iss_inc;

    logic [DMA_XFER_ID_W-1:0] wr_slot;
    logic [DMA_XFER_ID_W-1:0] iss_slot;

    logic full;
    logic push;
    logic cmpl_evt;

    logic [DMA_DESC_DEPTH-1:0] xfer_done_reg, xfer_done_next;
    logic irq_com_reg, irq_com_next;
    logic irq_qed_reg, irq_qed_next;

    // Descriptor storage; contents are don't-care until written, so no reset.
    logic [SRC_ADDR_W-1:0]   src_mem  [DMA_DESC_DEPTH];
    logic [DST_ADDR_W-1:0]   dst_mem  [DMA_DESC_DEPTH];
    logic [DMA_LENGTH_W-1:0] xlen_mem [DMA_DESC_DEPTH];
    logic [DMA_LENGTH_W-1:0] ylen_mem [DMA_DESC_DEPTH];
    logic [DMA_LENGTH_W-1:0] sstr_mem [DMA_DESC_DEPTH];
    logic [DMA_LENGTH_W-1:0] dstr_mem [DMA_DESC_DEPTH];

    assign wr_slot  = wr_ptr_reg[DMA_XFER_ID_W-1:0];
    assign iss_slot = iss_ptr_reg[DMA_XFER_ID_W-1:0];
    assign count    = wr_ptr_reg - head_ptr_reg;
    assign full     = (count == PTR_W'(DMA_DESC_DEPTH));
    assign push     = desc_wr_vld_i && !full;
    assign cmpl_evt = (state_reg == ST_ACTIVE) && xfer_cmpl_i;
    assign iss_inc  = iss_ptr_reg + PTR_W'(1);
    assign wr_ptr_next = push ? (wr_ptr_reg + PTR_W'(1)) : wr_ptr_reg;

    // Completion advances the issue pointer; head follows unless cycling.
    always_comb begin
        iss_ptr_next  = iss_ptr_reg;
        head_ptr_next = head_ptr_reg;
        if (cmpl_evt) begin
`ifdef ADMA_DESC_CYCLIC_EN
            if (chn_xfer_cyclic_i) begin
                // Keep every slot resident; wrap back to the oldest one.
                iss_ptr_next = (iss_inc == wr_ptr_next) ? head_ptr_reg : iss_inc;
            end else begin
                iss_ptr_next  = iss_inc;
                head_ptr_next = iss_inc;
            end
`else
            iss_ptr_next  = iss_inc;
            head_ptr_next = iss_inc;
`endif
        end
    end

`ifndef ADMA_DESC_CYCLIC_EN
    logic unused_cyclic;
    assign unused_cyclic = chn_xfer_cyclic_i;
`endif

    // Per-slot done bits: completion sets, a new push into the slot clears.
    genvar gi;
    generate
        for (gi = 0; gi < DMA_DESC_DEPTH; gi++) begin : g_done
            assign xfer_done_next[gi] =
                (cmpl_evt && (iss_slot == DMA_XFER_ID_W'(gi))) ? 1'b1 :
                (push && (wr_slot == DMA_XFER_ID_W'(gi)))      ? 1'b0 :
                xfer_done_reg[gi];
        end
    endgenerate

    // Sticky IRQ sources; a set event in the same cycle beats the clear.
    always_comb begin
        irq_com_next = (irq_com_reg && !irq_clr_i[0]) || cmpl_evt;
        irq_qed_next = (irq_qed_reg && !irq_clr_i[1]) || push;
    end

    // Issue FSM next-state and handshake/status outputs.
    always_comb begin
        state_next        = state_reg;
        desc_rd_vld_o     = 1'b0;
        active_xfer_len_o = '0;
        case (state_reg)
            ST_IDLE: begin
                if (chn_ctrl_en_i && (iss_ptr_reg != wr_ptr_reg))
                    state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                // Once offered, the descriptor stays offered until taken.
                desc_rd_vld_o = 1'b1;
                if (desc_rd_rdy_i)
                    state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                active_xfer_len_o = xlen_mem[iss_slot];
                if (xfer_cmpl_i)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, pointer and status registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_reg     <= ST_IDLE;
            wr_ptr_reg    <= '0;
            iss_ptr_reg   <= '0;
            head_ptr_reg  <= '0;
            xfer_done_reg <= '0;
            irq_com_reg   <= 1'b0;
            irq_qed_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_ptr_reg    <= wr_ptr_next;
            iss_ptr_reg   <= iss_ptr_next;
            head_ptr_reg  <= head_ptr_next;
            xfer_done_reg <= xfer_done_next;
            irq_com_reg   <= irq_com_next;
            irq_qed_reg   <= irq_qed_next;
        end
    end

    // Descriptor storage write on an accepted push.
    always_ff @(posedge aclk) begin
        if (push) begin
            src_mem[wr_slot]  <= desc_src_addr_i;
            dst_mem[wr_slot]  <= desc_dst_addr_i;
            xlen_mem[wr_slot] <= desc_xfer_xlen_i;
            ylen_mem[wr_slot] <= desc_xfer_ylen_i;
            sstr_mem[wr_slot] <= desc_src_strd_i;
            dstr_mem[wr_slot] <= desc_dst_strd_i;
        end
    end

    assign desc_wr_rdy_o       = !full;
    assign desc_rd_id_o        = iss_slot;
    assign desc_rd_src_addr_o  = src_mem[iss_slot];
    assign desc_rd_dst_addr_o  = dst_mem[iss_slot];
    assign desc_rd_xfer_xlen_o = xlen_mem[iss_slot];
    assign desc_rd_xfer_ylen_o = ylen_mem[iss_slot];
    assign desc_rd_src_strd_o  = sstr_mem[iss_slot];
    assign desc_rd_dst_strd_o  = dstr_mem[iss_slot];
    assign xfer_id_o           = wr_slot;
    assign active_xfer_id_o    = iss_slot;
    assign xfer_done_o         = xfer_done_reg;
    assign irq_com_o           = irq_com_reg;
    assign irq_qed_o           = irq_qed_reg;

endmodule
